// File: rtl/top_pkg.sv
// -----------------------------------------------------------------------------
// top_pkg
// Shared defaults and types for the LED bring-up counter.
//   CNT_WIDTH_DEF : default width of the free-running counter
//   LED_LSB_DEF   : default counter bit driven onto io_led[0]
//   LED_WIDTH_DEF : default number of LED outputs
//   cnt_t / led_t : counter and LED bus types at the default sizes
// -----------------------------------------------------------------------------
package top_pkg;

  localparam int CNT_WIDTH_DEF = 32;
  localparam int LED_LSB_DEF   = 2;
  localparam int LED_WIDTH_DEF = 4;

  typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;
  typedef logic [LED_WIDTH_DEF-1:0] led_t;

endpackage

// File: rtl/free_running_counter.sv
// -----------------------------------------------------------------------------
// free_running_counter
// Binary up-counter that advances on every rising clock edge and wraps from
// all-ones to zero. Reset is asynchronous and active-high.
//   clk   : clock, rising-edge active
//   rst   : asynchronous active-high reset, clears the count immediately
//   count : current counter value (WIDTH bits)
// -----------------------------------------------------------------------------
module free_running_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Natural modulo-2^WIDTH wrap: the carry out of the MSB is simply dropped.
  always_comb begin
    count_d = count_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top
// FPGA bring-up demo: a free-running counter whose bits
// [LED_LSB+LED_WIDTH-1:LED_LSB] drive the LED bus, so with the defaults the
// LEDs advance once every 4 clocks and repeat every 64 clocks.
//   clk    : board clock, rising-edge active
//   rst    : asynchronous active-high reset (release must be away from clk edge)
//   io_led : LED bus, combinational view of the counter slice
// Build option:
//   TOP_GRAY_LED_EN : when defined, io_led shows the Gray code of the slice
//                     (one LED toggles per step); otherwise plain binary.
// -----------------------------------------------------------------------------
module top
  import top_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int LED_LSB   = LED_LSB_DEF,
  parameter int LED_WIDTH = LED_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [LED_WIDTH-1:0] io_led
);

  if (CNT_WIDTH < LED_LSB + LED_WIDTH) begin : g_bad_width
    $error("top: CNT_WIDTH must be at least LED_LSB+LED_WIDTH");
  end

  logic [CNT_WIDTH-1:0] count;
  logic [LED_WIDTH-1:0] led_bin;
  logic                 unused_cnt;

  free_running_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .count (count)
  );

  // Only a slice of the counter reaches the pins; the rest is kept as a sink
  // so the upper bits still count (they set nothing visible in this block).
  assign unused_cnt = ^count;

  assign led_bin = count[LED_LSB +: LED_WIDTH];

  // No output register: the LEDs follow the counter in the same delta, and a
  // reset clears them without waiting for a clock edge.
`ifdef TOP_GRAY_LED_EN
  assign io_led = led_bin ^ (led_bin >> 1);
`else
  assign io_led = led_bin;
`endif

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top
// Directed bench for top: reset hold, count-up, LED wrap, asynchronous reset
// mid-run and restart, plus a 6-bit counter instance that wraps at 63 -> 0.
// Honours TOP_GRAY_LED_EN for the expected LED encoding.
// -----------------------------------------------------------------------------
module tb_top;

  logic       clk;
  logic       rst;
  logic [3:0] io_led;
  logic [3:0] io_led_w6;

  int n_checks = 0;
  int n_errors = 0;

  top dut (
    .clk    (clk),
    .rst    (rst),
    .io_led (io_led)
  );

  top #(
    .CNT_WIDTH (6)
  ) dut_w6 (
    .clk    (clk),
    .rst    (rst),
    .io_led (io_led_w6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed checkpoints: counter value after release -> LED value.
  localparam int NCP = 9;
  int         cp_k [NCP] = '{3, 4, 8, 12, 16, 50, 63, 64, 68};
`ifdef TOP_GRAY_LED_EN
  logic [3:0] cp_v [NCP] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd10, 4'd8, 4'd0, 4'd1};
`else
  logic [3:0] cp_v [NCP] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd12, 4'd15, 4'd0, 4'd1};
`endif

  function automatic logic [3:0] led_of(input int unsigned cnt);
    logic [3:0] b;
    b = 4'((cnt >> 2) & 32'd15);
`ifdef TOP_GRAY_LED_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_and_check(input int unsigned k, input logic [3:0] prev);
    @(posedge clk);
    #1;
    chk("count", {28'd0, io_led}, {28'd0, led_of(k)});
    chk("w6_wrap", {28'd0, io_led_w6}, {28'd0, led_of(k % 64)});
    for (int j = 0; j < NCP; j++) begin
      if (int'(k) == cp_k[j]) chk("checkpoint", {28'd0, io_led}, {28'd0, cp_v[j]});
    end
`ifdef TOP_GRAY_LED_EN
    if (io_led !== prev) chk("gray_one_bit", $countones(io_led ^ prev), 1);
`else
    if (prev == 4'hF && k % 64 == 0) chk("bin_wrap", {28'd0, io_led}, 32'd0);
`endif
  endtask

  initial begin
    logic [3:0] prev;
    rst = 1'b1;

    // Reset hold: edges at 5..95 ns with rst asserted.
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {28'd0, io_led}, 32'd0);
      chk("reset_hold_w6", {28'd0, io_led_w6}, 32'd0);
    end

    // Release at 100 ns, halfway between edges.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release", {28'd0, io_led}, 32'd0);

    // Count-up, wrap past 64, and on to count 101 (LED slice = 9).
    prev = io_led;
    for (int unsigned k = 1; k <= 101; k++) begin
      step_and_check(k, prev);
      prev = io_led;
    end
    chk("before_async", {28'd0, io_led}, {28'd0, led_of(32'd9 << 2)});

    // Asynchronous reset between edges: LEDs clear before the next edge.
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst", {28'd0, io_led}, 32'd0);
    chk("async_rst_w6", {28'd0, io_led_w6}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("async_hold", {28'd0, io_led}, 32'd0);
    end

    // Release and confirm the restart sequence 0,0,0,0,1.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("restart_0", {28'd0, io_led}, 32'd0);
    prev = io_led;
    for (int unsigned k = 1; k <= 5; k++) begin
      step_and_check(k, prev);
      prev = io_led;
    end
    chk("restart_end", {28'd0, io_led}, {28'd0, led_of(5)});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
